// File: rtl/seg_scan.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seg_scan : time-multiplexed 7-segment scanner with tear-free frame snapshot
//            and per-digit blink.
// Revision : 1.0
// -----------------------------------------------------------------------------
module seg_scan #(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK        = 50,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*DIGITS-1:0]   frame_i,
  input  logic [DIGITS-1:0]     blink_i,
  input  logic [7:0]            led_i,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic [7:0]            led_o,
  output logic                  frame_tick_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK);
  localparam logic [DW-1:0] DSEL_LAST = DW'(DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]          pre;
  logic [DW-1:0]          dsel;
  logic [FW-1:0]          fcnt;
  logic                   phase;
  logic [DIGITS-1:0][7:0] snap;
  logic [DIGITS-1:0]      bsnap;

  logic                   pre_wrap;
  logic                   frame_end;
  logic [7:0]             seg_next;
  logic [DIGITS-1:0]      dig_next;

  assign pre_wrap  = (pre == PRE_LAST);
  assign frame_end = pre_wrap && (dsel == DSEL_LAST);

  // Blanked-by-blink digits keep their enable so slot timing is unchanged.
  always_comb begin
    seg_next = 8'hFF;
    dig_next = '1;
    if (pre >= BLANK_END) begin
      dig_next[dsel] = 1'b0;
      if (!(bsnap[dsel] && !phase)) begin
        seg_next = ~snap[dsel];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      dsel  <= '0;
      fcnt  <= '0;
      phase <= 1'b1;
      snap  <= '0;
      bsnap <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) begin
        dsel <= (dsel == DSEL_LAST) ? '0 : dsel + DW'(1);
      end
      if (frame_end) begin
        snap  <= frame_i;
        bsnap <= blink_i;
        if (fcnt == FCNT_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end

  // Outputs are registered from the pre-edge counter state (one-cycle lag).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o        <= 8'hFF;
      dig_o        <= '1;
      led_o        <= 8'h00;
      frame_tick_o <= 1'b0;
    end else begin
      seg_o        <= seg_next;
      dig_o        <= dig_next;
      frame_tick_o <= frame_end;
      if (frame_end) begin
        led_o <= led_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_seg_scan : self-checking bench for seg_scan against a frame/slot model.
// Revision    : 1.0
// -----------------------------------------------------------------------------
module tb_seg_scan;

  localparam int DIGITS       = 6;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [47:0] frame_i;
  logic [5:0]  blink_i;
  logic [7:0]  led_i;
  logic [7:0]  seg_o;
  logic [5:0]  dig_o;
  logic [7:0]  led_o;
  logic        frame_tick_o;

  seg_scan #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK       (BLANK),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_i     (frame_i),
    .blink_i     (blink_i),
    .led_i       (led_i),
    .seg_o       (seg_o),
    .dig_o       (dig_o),
    .led_o       (led_o),
    .frame_tick_o(frame_tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  int          k;          // clock edges since reset release
  logic [47:0] m_snap;
  logic [5:0]  m_bsnap;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_dig;
  logic [7:0]  exp_led;
  logic        exp_tick;

  // Model: edge k shows slot (k mod FRAME); the frame shows data captured at
  // the end of the previous frame; blink is visible in even blink-periods.
  task automatic step();
    int c, d, p, f;
    bit vis;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; m_snap = '0; m_bsnap = '0;
      exp_seg = 8'hFF; exp_dig = 6'h3F; exp_led = 8'h00; exp_tick = 1'b0;
    end else begin
      c = k % FRAME; d = c / SCAN_DIV; p = c % SCAN_DIV; f = k / FRAME;
      vis = ((f / BLINK_FRAMES) % 2) == 0;
      if (p < BLANK) begin
        exp_dig = 6'h3F;
        exp_seg = 8'hFF;
      end else begin
        exp_dig = ~(6'b000001 << d);
        exp_seg = (m_bsnap[d] && !vis) ? 8'hFF : ~m_snap[8*d +: 8];
      end
      exp_tick = (c == FRAME - 1);
      if (c == FRAME - 1) begin
        m_snap = frame_i; m_bsnap = blink_i; exp_led = led_i;
      end
      k++;
    end
    #1;
  endtask

  function automatic logic [47:0] nz_frame();
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[8*i +: 8] = 8'($urandom_range(1, 255));
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frame_i = 48'({$urandom(), $urandom()});
      blink_i = 6'($urandom());
      led_i   = 8'($urandom());
      step();
      n_cmp++; if (seg_o !== 8'hFF) begin n_fail++; $display("FAIL reset_seg i=%0d got %h want ff", i, seg_o); end
      n_cmp++; if (dig_o !== 6'h3F) begin n_fail++; $display("FAIL reset_dig i=%0d got %h want 3f", i, dig_o); end
      n_cmp++; if (led_o !== 8'h00) begin n_fail++; $display("FAIL reset_led i=%0d got %h want 00", i, led_o); end
      n_cmp++; if (frame_tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick i=%0d got %b want 0", i, frame_tick_o); end
    end
  endtask

  task automatic test_display();
    int ticks = 0;
    frame_i = 48'h3F065B4F6676;
    blink_i = 6'b0;
    led_i   = 8'h02;
    rst_n   = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (i < 2 * FRAME - 1 && frame_tick_o === 1'b1) ticks++;
      n_cmp++; if (seg_o !== exp_seg) begin n_fail++; $display("FAIL disp_seg k=%0d got %h want %h", k, seg_o, exp_seg); end
      n_cmp++; if (dig_o !== exp_dig) begin n_fail++; $display("FAIL disp_dig k=%0d got %h want %h", k, dig_o, exp_dig); end
      n_cmp++; if (led_o !== exp_led) begin n_fail++; $display("FAIL disp_led k=%0d got %h want %h", k, led_o, exp_led); end
      n_cmp++; if (frame_tick_o !== exp_tick) begin n_fail++; $display("FAIL disp_tick k=%0d got %b want %b", k, frame_tick_o, exp_tick); end
      if (i == 23) begin
        n_cmp++; if (frame_tick_o !== 1'b1) begin n_fail++; $display("FAIL first_tick got %b want 1", frame_tick_o); end
      end
      if (i == 24) begin
        n_cmp++; if (dig_o !== 6'h3F || led_o !== 8'h02) begin n_fail++; $display("FAIL d0_blank dig=%h led=%h want 3f 02", dig_o, led_o); end
      end
      if (i == 25) begin
        n_cmp++; if (seg_o !== 8'h89 || dig_o !== 6'b111110) begin n_fail++; $display("FAIL d0_lit seg=%h dig=%b want 89 111110", seg_o, dig_o); end
      end
      if (i == 45) begin
        n_cmp++; if (seg_o !== 8'hC0 || dig_o !== 6'b011111) begin n_fail++; $display("FAIL d5_lit seg=%h dig=%b want c0 011111", seg_o, dig_o); end
      end
    end
    n_cmp++; if (ticks != 1) begin n_fail++; $display("FAIL tick_count got %0d want 1", ticks); end
  endtask

  task automatic test_tear_free();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (i == 9) frame_i = 48'h0;
      n_cmp++; if (seg_o !== exp_seg) begin n_fail++; $display("FAIL tear_seg k=%0d got %h want %h", k, seg_o, exp_seg); end
      n_cmp++; if (dig_o !== exp_dig) begin n_fail++; $display("FAIL tear_dig k=%0d got %h want %h", k, dig_o, exp_dig); end
      n_cmp++; if (frame_tick_o !== exp_tick) begin n_fail++; $display("FAIL tear_tick k=%0d got %b want %b", k, frame_tick_o, exp_tick); end
      if (i == 21) begin
        n_cmp++; if (seg_o !== 8'hC0) begin n_fail++; $display("FAIL tear_old_d5 got %h want c0", seg_o); end
      end
      if (i >= FRAME) begin
        n_cmp++; if (seg_o !== 8'hFF) begin n_fail++; $display("FAIL tear_new_blank k=%0d got %h want ff", k, seg_o); end
      end
    end
  endtask

  task automatic test_blink();
    int when;
    blink_i = 6'b000001;
    frame_i = nz_frame();
    for (int fr = 0; fr < 8; fr++) begin
      when = $urandom_range(0, FRAME - 1);
      for (int i = 0; i < FRAME; i++) begin
        step();
        if (i == when) begin frame_i = nz_frame(); led_i = 8'($urandom()); end
        n_cmp++; if (seg_o !== exp_seg) begin n_fail++; $display("FAIL blink_seg k=%0d got %h want %h", k, seg_o, exp_seg); end
        n_cmp++; if (dig_o !== exp_dig) begin n_fail++; $display("FAIL blink_dig k=%0d got %h want %h", k, dig_o, exp_dig); end
        n_cmp++; if (led_o !== exp_led) begin n_fail++; $display("FAIL blink_led k=%0d got %h want %h", k, led_o, exp_led); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do begin
      step();
      guard++;
    end while (((k - 1) % FRAME) != 13 && guard < 2 * FRAME);
    n_cmp++; if (dig_o !== 6'b110111) begin n_fail++; $display("FAIL mid_pre_dig got %b want 110111", dig_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (seg_o !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_seg got %h want ff", seg_o); end
    n_cmp++; if (dig_o !== 6'h3F) begin n_fail++; $display("FAIL mid_rst_dig got %h want 3f", dig_o); end
    n_cmp++; if (led_o !== 8'h00) begin n_fail++; $display("FAIL mid_rst_led got %h want 00", led_o); end
    n_cmp++; if (frame_tick_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tick got %b want 0", frame_tick_o); end
    for (int i = 0; i < 3; i++) step();
    blink_i = 6'h3F;
    frame_i = nz_frame();
    rst_n   = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_cmp++; if (seg_o !== exp_seg) begin n_fail++; $display("FAIL mid_seg k=%0d got %h want %h", k, seg_o, exp_seg); end
      n_cmp++; if (dig_o !== exp_dig) begin n_fail++; $display("FAIL mid_dig k=%0d got %h want %h", k, dig_o, exp_dig); end
      n_cmp++; if (led_o !== exp_led) begin n_fail++; $display("FAIL mid_led k=%0d got %h want %h", k, led_o, exp_led); end
    end
  endtask

  task automatic test_wrap();
    int last_tick = -1;
    logic [5:0] prev1, prev2;
    prev1 = dig_o;
    prev2 = dig_o;
    for (int i = 0; i < 100 * FRAME; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) frame_i = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) blink_i = 6'($urandom());
      if ($urandom_range(0, 7) == 0) led_i   = 8'($urandom());
      n_cmp++; if (seg_o !== exp_seg) begin n_fail++; $display("FAIL wrap_seg k=%0d got %h want %h", k, seg_o, exp_seg); end
      n_cmp++; if (dig_o !== exp_dig) begin n_fail++; $display("FAIL wrap_dig k=%0d got %h want %h", k, dig_o, exp_dig); end
      n_cmp++; if (led_o !== exp_led) begin n_fail++; $display("FAIL wrap_led k=%0d got %h want %h", k, led_o, exp_led); end
      if (frame_tick_o === 1'b1) begin
        if (last_tick >= 0) begin
          n_cmp++; if (i - last_tick != FRAME) begin n_fail++; $display("FAIL tick_spacing got %0d want %0d", i - last_tick, FRAME); end
        end
        last_tick = i;
      end
      if (i >= 2 && dig_o === 6'b111110 && prev1 !== 6'b111110) begin
        n_cmp++; if (prev1 !== 6'h3F || prev2 !== 6'b011111) begin n_fail++; $display("FAIL wrap_gap prev=%b,%b want 011111,111111", prev2, prev1); end
      end
      prev2 = prev1;
      prev1 = dig_o;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    k       = 0;
    rst_n   = 1'b0;
    frame_i = '0;
    blink_i = '0;
    led_i   = '0;
    test_reset();
    test_display();
    test_tear_free();
    test_blink();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
